// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath among four requesters.
// Grants one requester, drives registered operands, waits, captures result.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   req, op_sub       per-requester request and add(0)/sub(1) select
//   opa, opb          packed 4-bit operands, requester i on [4i+3:4i]
//   dp_a, dp_b        zero-extended winner operands to the datapath
//   dp_sub            selects subtractor outputs
//   dp_s, dp_cout,
//   dp_ovf            selected datapath result, carry, overflow
//   gnt, done         one-hot grant and one-cycle completion pulse
//   busy              high whenever an operation is in flight
//   res_abs, res_neg,
//   res_c, res_o      captured magnitude, sign, carry, overflow
module addsub_rr_arbiter #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  req,
    input  logic [3:0]  op_sub,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic        dp_sub,
    input  logic [31:0] dp_s,
    input  logic        dp_cout,
    input  logic        dp_ovf,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        busy,
    output logic [7:0]  res_abs,
    output logic        res_neg,
    output logic        res_c,
    output logic        res_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  win_q, win_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic        sub_q, sub_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic [7:0]  abs_q, abs_d;
    logic        neg_q, neg_d;
    logic        c_q, c_d;
    logic        o_q, o_d;

    logic [1:0]  win_c;
    logic        found_c;
    logic [1:0]  cand;
    logic [3:0]  opa_w;
    logic [3:0]  opb_w;
    logic [7:0]  mag_c;
    logic        unused_dp;

    // Only the low byte and the sign of the datapath result matter:
    // operands are 4-bit, so |result| always fits in 8 bits.
    assign unused_dp = ^dp_s[30:8];

    // First requesting index at or after ptr_q, wrapping mod 4.
    always_comb begin
        win_c   = ptr_q;
        found_c = 1'b0;
        cand    = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found_c && req[cand]) begin
                win_c   = cand;
                found_c = 1'b1;
            end
        end
    end

    assign opa_w = opa[{win_c, 2'b00} +: 4];
    assign opb_w = opb[{win_c, 2'b00} +: 4];

    // Two's-complement magnitude of the low byte.
    assign mag_c = dp_s[31] ? (8'd0 - dp_s[7:0]) : dp_s[7:0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        abs_d   = abs_q;
        neg_d   = neg_q;
        c_d     = c_q;
        o_d     = o_q;
        unique case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    win_d   = win_c;
                    a_d     = opa_w;
                    b_d     = opb_w;
                    sub_d   = op_sub[win_c];
                    gnt_d   = 4'b0001 << win_c;
                    cnt_d   = 4'(WAIT_CYC);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q - 4'd1;
                // <= 1 so an out-of-range count cannot wedge the FSM
                if (cnt_q <= 4'd1) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                abs_d   = mag_c;
                neg_d   = dp_s[31];
                c_d     = dp_cout;
                o_d     = dp_ovf;
                done_d  = gnt_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = win_q + 2'd1;
                gnt_d   = 4'b0000;
                done_d  = 4'b0000;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            win_q   <= 2'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            sub_q   <= 1'b0;
            gnt_q   <= 4'd0;
            done_q  <= 4'd0;
            abs_q   <= 8'd0;
            neg_q   <= 1'b0;
            c_q     <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            abs_q   <= abs_d;
            neg_q   <= neg_d;
            c_q     <= c_d;
            o_q     <= o_d;
        end
    end

    assign dp_a    = {28'd0, a_q};
    assign dp_b    = {28'd0, b_q};
    assign dp_sub  = sub_q;
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);
    assign res_abs = abs_q;
    assign res_neg = neg_q;
    assign res_c   = c_q;
    assign res_o   = o_q;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Testbench for addsub_rr_arbiter: two instances (WAIT_CYC 1 and 4),
// vector table, directed sequences, random traffic vs transaction model.
module tb_addsub_rr_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst    [2];
    logic [3:0]  req    [2];
    logic [3:0]  op_sub [2];
    logic [15:0] opa    [2];
    logic [15:0] opb    [2];
    logic        flip   [2];

    wire [31:0] dp_a    [2];
    wire [31:0] dp_b    [2];
    wire        dp_sub  [2];
    wire [31:0] dp_s    [2];
    wire        dp_cout [2];
    wire        dp_ovf  [2];
    wire [3:0]  gnt     [2];
    wire [3:0]  done    [2];
    wire        busy    [2];
    wire [7:0]  res_abs [2];
    wire        res_neg [2];
    wire        res_c   [2];
    wire        res_o   [2];

    int n_chk = 0;
    int n_err = 0;

    // Shared 32-bit add/sub unit; flip injects an overflow flag.
    function automatic logic [33:0] dpm(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic sub,
                                        input logic fl);
        logic [32:0] t;
        logic        ov;
        t  = sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1)
                 : ({1'b0, a} + {1'b0, b});
        ov = (a[31] == (b[31] ^ sub)) && (t[31] != a[31]);
        return {ov ^ fl, t[32], t[31:0]};
    endfunction

    assign {dp_ovf[0], dp_cout[0], dp_s[0]} =
        dpm(dp_a[0], dp_b[0], dp_sub[0], flip[0]);
    assign {dp_ovf[1], dp_cout[1], dp_s[1]} =
        dpm(dp_a[1], dp_b[1], dp_sub[1], flip[1]);

    addsub_rr_arbiter #(.WAIT_CYC(1)) dut0 (
        .CLK(CLK), .RST(rst[0]), .req(req[0]), .op_sub(op_sub[0]),
        .opa(opa[0]), .opb(opb[0]), .dp_a(dp_a[0]), .dp_b(dp_b[0]),
        .dp_sub(dp_sub[0]), .dp_s(dp_s[0]), .dp_cout(dp_cout[0]),
        .dp_ovf(dp_ovf[0]), .gnt(gnt[0]), .done(done[0]),
        .busy(busy[0]), .res_abs(res_abs[0]), .res_neg(res_neg[0]),
        .res_c(res_c[0]), .res_o(res_o[0])
    );

    addsub_rr_arbiter #(.WAIT_CYC(4)) dut1 (
        .CLK(CLK), .RST(rst[1]), .req(req[1]), .op_sub(op_sub[1]),
        .opa(opa[1]), .opb(opb[1]), .dp_a(dp_a[1]), .dp_b(dp_b[1]),
        .dp_sub(dp_sub[1]), .dp_s(dp_s[1]), .dp_cout(dp_cout[1]),
        .dp_ovf(dp_ovf[1]), .gnt(gnt[1]), .done(done[1]),
        .busy(busy[1]), .res_abs(res_abs[1]), .res_neg(res_neg[1]),
        .res_c(res_c[1]), .res_o(res_o[1])
    );

    function automatic int wc(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input int d, input string tg,
                           input logic [3:0] eg, input logic [3:0] ed,
                           input logic ebusy, input logic [31:0] ea,
                           input logic [31:0] eb, input logic es,
                           input logic [7:0] eabs, input logic en,
                           input logic ec, input logic eo);
        chk({tg, "_gnt"},     32'(gnt[d]),     32'(eg));
        chk({tg, "_done"},    32'(done[d]),    32'(ed));
        chk({tg, "_busy"},    32'(busy[d]),    32'(ebusy));
        chk({tg, "_dp_a"},    dp_a[d],         ea);
        chk({tg, "_dp_b"},    dp_b[d],         eb);
        chk({tg, "_dp_sub"},  32'(dp_sub[d]),  32'(es));
        chk({tg, "_res_abs"}, 32'(res_abs[d]), 32'(eabs));
        chk({tg, "_res_neg"}, 32'(res_neg[d]), 32'(en));
        chk({tg, "_res_c"},   32'(res_c[d]),   32'(ec));
        chk({tg, "_res_o"},   32'(res_o[d]),   32'(eo));
    endtask

    task automatic chk_reset(input int d, input string tg);
        chk_out(d, tg, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0,
                8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        req[d] = 4'd0;
        @(negedge CLK);
        rst[d] = 1'b0;
    endtask

    // Single operation from an idle negedge; ends at the next idle negedge.
    task automatic run_op(input int d, input int id, input logic [3:0] a,
                          input logic [3:0] b, input logic sub,
                          input bit drop_mid);
        int t;
        logic [3:0] oh;
        oh = 4'(1 << id);
        opa[d][4*id +: 4] = a;
        opb[d][4*id +: 4] = b;
        op_sub[d][id]     = sub;
        req[d]            = oh;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
            if (t == 1) begin
                chk("op_gnt",    32'(gnt[d]),    32'(oh));
                chk("op_busy",   32'(busy[d]),   32'd1);
                chk("op_dp_a",   dp_a[d],        32'(a));
                chk("op_dp_b",   dp_b[d],        32'(b));
                chk("op_dp_sub", 32'(dp_sub[d]), 32'(sub));
                if (drop_mid) req[d] = 4'd0;
            end
        end while (done[d] == 4'd0 && t < 40);
        chk("op_latency",  32'(t),       32'(wc(d) + 2));
        chk("op_done_id",  32'(done[d]), 32'(oh));
        chk("op_gnt_held", 32'(gnt[d]),  32'(oh));
        req[d] = 4'd0;
        @(negedge CLK);
        chk("op_idle_busy", 32'(busy[d]), 32'd0);
        chk("op_idle_gnt",  32'(gnt[d]),  32'd0);
        chk("op_idle_done", 32'(done[d]), 32'd0);
    endtask

    // Requesters in m all request at once and drop on their own done;
    // expects winners in ord[] at cycles 3, 7, 11... (WAIT_CYC=1).
    task automatic rr_seq(input int d, input logic [3:0] m,
                          input int ord[4], input int n);
        int t;
        int nd;
        opa[d]    = 16'h4321;
        opb[d]    = 16'h1234;
        op_sub[d] = 4'd0;
        req[d]    = m;
        t  = 0;
        nd = 0;
        while (nd < n && t < 60) begin
            @(negedge CLK);
            t++;
            chk("rr_gnt_onehot", 32'($onehot0(gnt[d])), 32'd1);
            if (done[d] != 4'd0) begin
                chk("rr_done_id",   32'(done[d]), 32'(1 << ord[nd]));
                chk("rr_done_time", 32'(t),       32'(3 + 4 * nd));
                req[d] = req[d] & ~done[d];
                nd++;
            end
        end
        chk("rr_count", 32'(nd), 32'(n));
        req[d] = 4'd0;
        @(negedge CLK);
        chk("rr_idle_busy", 32'(busy[d]), 32'd0);
    endtask

    // Random traffic checked each cycle against a transaction-level model.
    task automatic random_run(input int d, input int ncyc);
        int         m_ptr;
        int         m_k;
        int         m_w;
        int         r;
        logic [3:0] ma, mb;
        logic       msub;
        logic [3:0] e_gnt, e_done;
        logic       e_busy, e_sub, e_neg, e_c, e_o;
        logic [31:0] e_a, e_b;
        logic [7:0] e_abs;
        m_ptr = 0; m_k = 0; m_w = 0;
        ma = 0; mb = 0; msub = 0;
        e_gnt = 0; e_done = 0; e_busy = 0; e_sub = 0;
        e_a = 0; e_b = 0; e_abs = 0; e_neg = 0; e_c = 0; e_o = 0;
        for (int c = 0; c < ncyc; c++) begin
            chk_out(d, "rnd", e_gnt, e_done, e_busy, e_a, e_b, e_sub,
                    e_abs, e_neg, e_c, e_o);
            for (int i = 0; i < 4; i++) begin
                if (req[d][i] && e_done[i]) begin
                    req[d][i] = 1'b0;
                end else if (req[d][i] && e_busy && e_gnt[i] &&
                             $urandom_range(0, 15) == 0) begin
                    req[d][i] = 1'b0;
                end else if (!req[d][i] &&
                             $urandom_range(0, 3) == 0) begin
                    opa[d][4*i +: 4] = 4'($urandom_range(0, 15));
                    opb[d][4*i +: 4] = 4'($urandom_range(0, 15));
                    op_sub[d][i]     = 1'($urandom_range(0, 1));
                    req[d][i]        = 1'b1;
                end
            end
            flip[d] = 1'($urandom_range(0, 1));
            if (m_k == 0) begin
                if (req[d] != 4'd0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (req[d][(m_ptr + k) % 4]) begin
                            m_w = (m_ptr + k) % 4;
                            break;
                        end
                    end
                    ma     = opa[d][4*m_w +: 4];
                    mb     = opb[d][4*m_w +: 4];
                    msub   = op_sub[d][m_w];
                    m_k    = 1;
                    e_gnt  = 4'(1 << m_w);
                    e_busy = 1'b1;
                    e_a    = 32'(ma);
                    e_b    = 32'(mb);
                    e_sub  = msub;
                end
            end else if (m_k == wc(d) + 1) begin
                r      = msub ? int'(ma) - int'(mb) : int'(ma) + int'(mb);
                e_abs  = 8'((r < 0) ? -r : r);
                e_neg  = (r < 0);
                e_c    = msub && (ma >= mb);
                e_o    = flip[d];
                e_done = 4'(1 << m_w);
                m_k++;
            end else if (m_k == wc(d) + 2) begin
                m_k    = 0;
                m_ptr  = (m_w + 1) % 4;
                e_gnt  = 4'd0;
                e_done = 4'd0;
                e_busy = 1'b0;
            end else begin
                m_k++;
            end
            @(negedge CLK);
        end
        req[d] = 4'd0;
    endtask

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [7:0] ex_abs;
        logic       ex_neg;
        logic       ex_c;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{0, 4'd3,  4'd5,  1'b0, 8'd8,  1'b0, 1'b0};
        tbl[1] = '{1, 4'd3,  4'd5,  1'b1, 8'd2,  1'b1, 1'b0};
        tbl[2] = '{2, 4'd9,  4'd4,  1'b1, 8'd5,  1'b0, 1'b1};
        tbl[3] = '{3, 4'd15, 4'd15, 1'b0, 8'd30, 1'b0, 1'b0};
        tbl[4] = '{0, 4'd0,  4'd15, 1'b1, 8'd15, 1'b1, 1'b0};
        tbl[5] = '{1, 4'd7,  4'd7,  1'b1, 8'd0,  1'b0, 1'b1};
        tbl[6] = '{2, 4'd0,  4'd0,  1'b0, 8'd0,  1'b0, 1'b0};
        tbl[7] = '{3, 4'd15, 4'd0,  1'b1, 8'd15, 1'b0, 1'b1};

        for (int d = 0; d < 2; d++) begin
            rst[d]    = 1'b1;
            req[d]    = 4'd0;
            op_sub[d] = 4'd0;
            opa[d]    = 16'd0;
            opb[d]    = 16'd0;
            flip[d]   = 1'b0;
        end
        repeat (2) @(negedge CLK);
        chk_reset(0, "reset0");
        chk_reset(1, "reset1");
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(0, tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub, 1'b0);
            chk("tbl_res_abs", 32'(res_abs[0]), 32'(tbl[i].ex_abs));
            chk("tbl_res_neg", 32'(res_neg[0]), 32'(tbl[i].ex_neg));
            chk("tbl_res_c",   32'(res_c[0]),   32'(tbl[i].ex_c));
            chk("tbl_res_o",   32'(res_o[0]),   32'd0);
        end

        run_op(1, 2, 4'd15, 4'd15, 1'b0, 1'b1);
        chk("w4_res_abs", 32'(res_abs[1]), 32'd30);
        chk("w4_res_neg", 32'(res_neg[1]), 32'd0);
        run_op(1, 0, 4'd2, 4'd9, 1'b1, 1'b0);
        chk("w4_sub_abs", 32'(res_abs[1]), 32'd7);
        chk("w4_sub_neg", 32'(res_neg[1]), 32'd1);
        chk("w4_sub_c",   32'(res_c[1]),   32'd0);

        do_reset(0);
        rr_seq(0, 4'b1111, '{0, 1, 2, 3}, 4);
        run_op(0, 1, 4'd6, 4'd2, 1'b0, 1'b0);
        rr_seq(0, 4'b1011, '{3, 0, 1, 0}, 3);

        opa[0][3:0] = 4'd3;
        opb[0][3:0] = 4'd5;
        op_sub[0]   = 4'd0;
        req[0]      = 4'b0001;
        @(negedge CLK);
        chk("rstmid_busy", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1;
        req[0] = 4'd0;
        @(negedge CLK);
        chk_reset(0, "rstmid");
        rst[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            chk("rstmid_no_done", 32'(done[0]), 32'd0);
        end

        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            random_run(d, 400);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/addsub_rr_arbiter.md
# addsub_rr_arbiter

Round-robin controller that shares one 32-bit adder and one 32-bit subtractor datapath among four requesters. Each requester presents two 4-bit unsigned operands and an add/sub select. The block grants one requester at a time and drives the shared datapath with registered, zero-extended operands. After a fixed settle time it captures the result as magnitude, sign, carry and overflow. It sits between the switch/button front-ends and the shared arithmetic unit, ahead of the 7-segment display path.

## Interface
- `WAIT_CYC`, default 1: cycles the datapath is allowed to settle before capture; legal range 1..15.
- `CLK` in 1: single clock, all state on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `req` in 4: per-requester request, bit i = requester i.
- `op_sub` in 4: per-requester select, 0 = add, 1 = subtract.
- `opa` in 16: packed operand A, requester i on bits [4i+3:4i].
- `opb` in 16: packed operand B, same packing as `opa`.
- `dp_a` out 32: to datapath, `{28'b0, A}` of the winner, registered.
- `dp_b` out 32: to datapath, `{28'b0, B}` of the winner, registered.
- `dp_sub` out 1: selects the subtractor outputs, registered.
- `dp_s` in 32: selected datapath sum or difference.
- `dp_cout` in 1: selected datapath carry.
- `dp_ovf` in 1: selected datapath overflow.
- `gnt` out 4: one-hot grant, held from grant through done.
- `done` out 4: one-hot, single-cycle completion pulse to the winner.
- `busy` out 1: high in every state except IDLE.
- `res_abs` out 8: `|dp_s|[7:0]` captured for the last completed operation.
- `res_neg` out 1: 1 when the captured `dp_s[31]` was 1.
- `res_c` out 1: captured `dp_cout`.
- `res_o` out 1: captured `dp_ovf`.

## Operation
- FSM has four states: IDLE, ISSUE, CAPT, DONE.
- **IDLE:** if `req != 0`, select winner `w` as the first set bit scanning `ptr, ptr+1, … mod 4`.
  - Register `dp_a`, `dp_b` and `dp_sub` from requester `w`.
  - Set `gnt[w]`, load `cnt = WAIT_CYC`, go to ISSUE.
  - If `req == 0`, stay in IDLE with all outputs held.
- **ISSUE:** decrement `cnt` each cycle. When `cnt == 1` on a cycle, go to CAPT on the next edge. Operands stay frozen and `req` changes are ignored.
- **CAPT:** on the edge leaving CAPT, latch the result, assert `done[w]` and go to DONE.
  - If `dp_s[31] == 0`: `res_abs = dp_s[7:0]`, `res_neg = 0`.
  - Otherwise: `res_abs = (-dp_s)[7:0]`, `res_neg = 1`.
  - `res_c = dp_cout`, `res_o = dp_ovf`.
- **DONE:** `done[w] = 1` for exactly this cycle, `gnt[w]` stays 1.
  - On exit: `ptr = (w+1) mod 4`, `gnt = 0`, `done = 0`, go to IDLE.
- **Request rules:**
  - A requester holds `req` until it sees `done`.
  - A `req` still high in the IDLE cycle after DONE counts as a new request.
  - A registered requester that drops `req` on the `done` edge is never double-served.
- If a requester drops `req` mid-operation, the operation still completes and `done` still pulses.
- `res_*` hold their value until the next capture; they are never cleared except by reset.
- **Width rule:** operands are 4-bit unsigned.
  - Add result is 0..30 with `dp_ovf = 0`.
  - Sub result is −15..15.
  - The 8-bit magnitude never truncates.

## Timing
- **Reset values:** state IDLE, `ptr = 0`, `cnt = 0`, all outputs 0 (`gnt`, `done`, `busy`, `dp_a`, `dp_b`, `dp_sub`, `res_abs`, `res_neg`, `res_c`, `res_o`).
- **Reset mid-operation:** abort immediately; no `done` is issued and the outputs take their reset values on the next edge.
- **Latency:** `req` sampled in IDLE at cycle 0.
  - `gnt`, `busy` and `dp_*` valid from cycle 1.
  - CAPT in cycle `WAIT_CYC+1`.
  - `done` and new `res_*` in cycle `WAIT_CYC+2`.
  - Back in IDLE at cycle `WAIT_CYC+3`.
- **Throughput:** one operation per `WAIT_CYC+3` cycles under continuous requests.
- Arbitration is fair: any requester holding `req` is served within 4 operations.

## Test plan
- **Single add:** after reset, `req = 0001`, A0 = 3, B0 = 5, add → `done[0]` in cycle 3 (`WAIT_CYC = 1`); `res_abs = 8`, `res_neg = 0`, `res_o = 0`, `dp_a = 3`.
- **Negative sub:** `req = 0010`, A1 = 3, B1 = 5, sub → `dp_sub = 1`; `res_abs = 2`, `res_neg = 1`, `res_c = dp_cout` sampled in CAPT.
- **Round-robin order:** `req = 1111` from reset, each requester dropping on its own `done` → grants 0, 1, 2, 3 in order, one `done` per 4 cycles, `gnt` always one-hot.
- **Fairness:** `ptr = 2` (after serving requester 1), `req = 1011` → grant 3, then 0, then 1.
- **Reset mid-op:** assert `RST` in ISSUE → next cycle IDLE with `gnt = 0`; no `done` ever pulses for that operation; `res_*` = 0.
- **Parameter and request drop:** `WAIT_CYC = 4`, A = 15, B = 15, add → `done` in cycle 6 with `res_abs = 30`; dropping `req` in ISSUE still yields `done`.
